// File: rtl/display_scan_3digit_if.sv
// Digit-scan bus between the data source, the scanner and the 7-segment decoder.
//   VALUE    : packed BCD digits, nibble i at [4i+3:4i]   (source -> scanner)
//   LOAD     : one-cycle strobe capturing VALUE            (source -> scanner)
//   LZ_BLANK : leading-zero suppression enable             (source -> scanner)
//   D        : registered digit code for the decoder       (scanner -> decoder)
//   EN       : registered active-low digit enables         (scanner -> display)
//   IDX      : registered index of the presented digit     (scanner -> observer)
// master drives the data side, slave is the scanner.
interface display_scan_3digit_if #(
  parameter int unsigned DIGITS = 3
);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] VALUE;
  logic                LOAD;
  logic                LZ_BLANK;
  logic [3:0]          D;
  logic [DIGITS-1:0]   EN;
  logic [IdxW-1:0]     IDX;

  modport master (
    output VALUE, LOAD, LZ_BLANK,
    input  D, EN, IDX
  );

  modport slave (
    input  VALUE, LOAD, LZ_BLANK,
    output D, EN, IDX
  );
endinterface

// File: rtl/display_scan_3digit.sv
// Time-multiplexed scanner for a DIGITS-wide BCD value on a shared 4-bit digit bus.
// Each digit gets a BLANK_CYCLES gap (all enables high) followed by a DWELL_CYCLES
// slot with its active-low enable asserted, so the downstream registered decoder
// has settled before the digit lights up.
//   CLK : system clock, rising edge
//   RST : synchronous active-high reset
//   bus : slave side of display_scan_3digit_if (VALUE/LOAD/LZ_BLANK in, D/EN/IDX out)
module display_scan_3digit #(
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned DWELL_CYCLES = 16000,
  parameter int unsigned BLANK_CYCLES = 120
) (
  input  logic                   CLK,
  input  logic                   RST,
  display_scan_3digit_if.slave   bus
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MaxCnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt);

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [3:0]          d_q;
  logic [DIGITS-1:0]   en_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic [4*DIGITS-1:0] active_q;
  logic                first_q;   // first cycle after reset also acts as a frame boundary

  logic [IdxW-1:0]     idx_nxt;
  logic                blank_end;
  logic                show_end;
  logic                frame_copy;
  logic [4*DIGITS-1:0] active_nxt;
  logic [DIGITS-1:0]   upper_zero;
  logic [DIGITS-1:0]   onehot;
  logic                lit;
  logic [DIGITS-1:0]   en_show;
  logic                zero_acc;

  always_comb begin
    idx_nxt    = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    blank_end  = (state_q == StBlank) && (cnt_q == BlankLast);
    show_end   = (state_q == StShow) && (cnt_q == DwellLast);
    frame_copy = first_q || (show_end && (idx_nxt == '0));

    // A LOAD landing on the boundary bypasses the shadow so it is not a frame late.
    active_nxt = active_q;
    if (frame_copy) begin
      active_nxt = bus.LOAD ? bus.VALUE : shadow_q;
    end

    // upper_zero[i]: nibbles i..DIGITS-1 of the displayed frame are all zero.
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_acc      = zero_acc & (active_q[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_acc;
    end

    lit           = !(bus.LZ_BLANK && (idx_q != '0) && upper_zero[idx_q]);
    onehot        = '0;
    onehot[idx_q] = 1'b1;
    en_show       = lit ? ~onehot : '1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StBlank;
      cnt_q    <= '0;
      idx_q    <= '0;
      d_q      <= 4'h0;
      en_q     <= '1;
      shadow_q <= '0;
      active_q <= '0;
      first_q  <= 1'b1;
    end else begin
      first_q  <= 1'b0;
      active_q <= active_nxt;
      if (bus.LOAD) begin
        shadow_q <= bus.VALUE;
      end

      unique case (state_q)
        StBlank: begin
          // After reset the digit already on D must follow the freshly copied frame.
          if (first_q) begin
            d_q <= active_nxt[{idx_q, 2'b00} +: 4];
          end
          if (blank_end) begin
            state_q <= StShow;
            cnt_q   <= '0;
            en_q    <= en_show;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            en_q  <= '1;
          end
        end
        StShow: begin
          if (show_end) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= idx_nxt;
            d_q     <= active_nxt[{idx_nxt, 2'b00} +: 4];
            en_q    <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            en_q  <= en_show;   // LZ_BLANK is honoured every cycle of the slot
          end
        end
        default: begin
          state_q <= StBlank;
          cnt_q   <= '0;
          en_q    <= '1;
        end
      endcase
    end
  end

  assign bus.D   = d_q;
  assign bus.EN  = en_q;
  assign bus.IDX = idx_q;

endmodule
